// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the board-side request logic and the CPU run controller.
// Requests are single-clk pulses, sampled on the rising clk edge; no ready/ack is returned.
interface cpu_run_ctrl_if;
  logic [1:0]  rateSel;
  logic        runReq;
  logic        stepReq;
  logic        stepMode;
  logic [2:0]  cycleIn;
  logic [11:0] pcIn;
  logic [11:0] bpAddr;
  logic        bpEn;
  logic        cpuEn;
  logic        halted;
  logic        bpHit;
  logic [1:0]  stateOut;

  modport master (
    output rateSel, runReq, stepReq, stepMode, cycleIn, pcIn, bpAddr, bpEn,
    input  cpuEn, halted, bpHit, stateOut
  );

  modport slave (
    input  rateSel, runReq, stepReq, stepMode, cycleIn, pcIn, bpAddr, bpEn,
    output cpuEn, halted, bpHit, stateOut
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Single-domain execution controller for the 4004-style core: run/halt, cycle and
// instruction stepping, rate divider and PC breakpoint, producing a one-clk cpuEn.
module cpu_run_ctrl #(
  parameter int unsigned DIV_SLOW = 12000000,
  parameter int unsigned DIV_FAST = 1200000
) (
  input logic            clk,
  input logic            rstN,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    HALT     = 2'b00,
    RUN      = 2'b01,
    STEP_CYC = 2'b10,
    STEP_INS = 2'b11
  } state_t;

  localparam logic [23:0] TERM_SLOW = 24'(DIV_SLOW - 1);
  localparam logic [23:0] TERM_FAST = 24'(DIV_FAST - 1);

  state_t      state;
  logic        tick;
  logic [23:0] divCnt;
  logic [1:0]  rateSelQ;
  logic        bpMask;
  logic        bpHitQ;

  logic        runActive;
  logic        rateChange;
  logic        divCounting;
  logic [23:0] divTerm;
  logic        bpStop;
  logic        cpuEnInt;

  assign runActive   = (state == RUN);
  assign rateChange  = (bus.rateSel != rateSelQ);
  assign divCounting = runActive && ((bus.rateSel == 2'b01) || (bus.rateSel == 2'b10));
  assign divTerm     = (bus.rateSel == 2'b01) ? TERM_SLOW : TERM_FAST;

  // The breakpoint is judged at the start of an instruction (cycle A1), before it executes.
  assign bpStop = runActive && bus.bpEn && !bpMask &&
                  (bus.cycleIn == 3'd0) && (bus.pcIn == bus.bpAddr);

  always_comb begin
    cpuEnInt = 1'b0;
    case (state)
      RUN:      cpuEnInt = ((bus.rateSel == 2'b11) || tick) && !bpStop;
      STEP_CYC: cpuEnInt = 1'b1;
      STEP_INS: cpuEnInt = 1'b1;
      default:  cpuEnInt = 1'b0;
    endcase
  end

  // Rate divider: restarts from zero on RUN entry and on any rate change so the
  // first pulse after either event lands a full period later.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      divCnt   <= 24'd0;
      tick     <= 1'b0;
      rateSelQ <= 2'b00;
    end else begin
      rateSelQ <= bus.rateSel;
      if (!runActive || rateChange) begin
        divCnt <= 24'd0;
        tick   <= 1'b0;
      end else if (divCounting) begin
        if (divCnt == divTerm) begin
          divCnt <= 24'd0;
          tick   <= 1'b1;
        end else begin
          divCnt <= divCnt + 24'd1;
          tick   <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= HALT;
      bpMask <= 1'b0;
      bpHitQ <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          if (bus.runReq) begin
            state  <= RUN;
            bpHitQ <= 1'b0;
            bpMask <= 1'b1;
          end else if (bus.stepReq) begin
            state <= bus.stepMode ? STEP_INS : STEP_CYC;
          end
        end
        RUN: begin
          // Mask only covers the instruction we resumed on; drop it once the CPU moves.
          if (cpuEnInt) bpMask <= 1'b0;
          if (bpStop) begin
            state  <= HALT;
            bpHitQ <= 1'b1;
          end else if (bus.runReq) begin
            state <= HALT;
          end
        end
        STEP_CYC: state <= HALT;
        STEP_INS: begin
          if (bus.cycleIn == 3'd7) state <= HALT;
        end
        default: state <= HALT;
      endcase
    end
  end

  assign bus.cpuEn    = cpuEnInt;
  assign bus.halted   = (state == HALT);
  assign bus.bpHit    = bpHitQ;
  assign bus.stateOut = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny CPU model that advances cycle/PC on cpuEn.
module tb_cpu_run_ctrl;

  logic clk;
  logic rstN;
  int   errors;
  int   checks;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(.DIV_SLOW(6), .DIV_FAST(4)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CPU model: cycle 0..7, PC increments when cycle wraps; loadable for jumps
  logic [2:0]  mCyc;
  logic [11:0] mPc;
  logic        mLoad;
  logic [2:0]  mLoadCyc;
  logic [11:0] mLoadPc;

  always @(posedge clk) begin
    if (mLoad) begin
      mCyc <= mLoadCyc;
      mPc  <= mLoadPc;
    end else if (bus.cpuEn) begin
      mCyc <= mCyc + 3'd1;
      if (mCyc == 3'd7) mPc <= mPc + 12'd1;
    end
  end

  assign bus.cycleIn = mCyc;
  assign bus.pcIn    = mPc;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    bus.runReq = 1'b1;
    next_cycle();
    bus.runReq = 1'b0;
  endtask

  task automatic pulse_step(input logic mode);
    bus.stepMode = mode;
    bus.stepReq  = 1'b1;
    next_cycle();
    bus.stepReq  = 1'b0;
  endtask

  task automatic load_model(input logic [2:0] cyc, input logic [11:0] pc);
    mLoadCyc = cyc;
    mLoadPc  = pc;
    mLoad    = 1'b1;
    next_cycle();
    mLoad    = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rstN = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (bus.stateOut !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", bus.stateOut); end
    checks++; if (bus.cpuEn !== 1'b0) begin errors++; $display("FAIL reset_cpuEn: got %b expected 0", bus.cpuEn); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b expected 1", bus.halted); end
    checks++; if (bus.bpHit !== 1'b0) begin errors++; $display("FAIL reset_bpHit: got %b expected 0", bus.bpHit); end
    rstN = 1'b1;
    next_cycle();
  endtask

  task automatic test_step_cyc();
    load_model(3'd0, 12'h100);
    pulse_step(1'b0);
    checks++; if (bus.stateOut !== 2'b10) begin errors++; $display("FAIL stepc_state: got %b expected 10", bus.stateOut); end
    checks++; if (bus.cpuEn !== 1'b1) begin errors++; $display("FAIL stepc_cpuEn: got %b expected 1", bus.cpuEn); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL stepc_halted: got %b expected 0", bus.halted); end
    next_cycle();
    checks++; if (bus.stateOut !== 2'b00) begin errors++; $display("FAIL stepc_back: got %b expected 00", bus.stateOut); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL stepc_halted_back: got %b expected 1", bus.halted); end
    next_cycle();
    next_cycle();
    checks++; if (mCyc !== 3'd1) begin errors++; $display("FAIL stepc_one_pulse: cycle got %0d expected 1", mCyc); end
  endtask

  task automatic test_step_ins();
    int first6;
    int total;
    first6 = 0;
    total  = 0;
    load_model(3'd2, 12'h100);
    pulse_step(1'b1);
    for (int i = 0; i < 12; i++) begin
      if (bus.cpuEn === 1'b1) begin
        total++;
        if (i < 6) first6++;
      end
      next_cycle();
    end
    checks++; if (total !== 6) begin errors++; $display("FAIL stepi_count: got %0d expected 6", total); end
    checks++; if (first6 !== 6) begin errors++; $display("FAIL stepi_contig: got %0d expected 6", first6); end
    checks++; if (mCyc !== 3'd0) begin errors++; $display("FAIL stepi_cycle: got %0d expected 0", mCyc); end
    checks++; if (mPc !== 12'h101) begin errors++; $display("FAIL stepi_pc: got %h expected 101", mPc); end
    checks++; if (bus.stateOut !== 2'b00) begin errors++; $display("FAIL stepi_state: got %b expected 00", bus.stateOut); end
  endtask

  // scoreboard of expected cpuEn cycle indices after the run edge
  logic [7:0] exp_q[$];

  task automatic run_pulse_window(input string name, input int len);
    logic [7:0] e;
    for (int i = 0; i < len; i++) begin
      if (bus.cpuEn === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_extra: cpuEn at index %0d, none expected", name, i);
        end else begin
          e = exp_q.pop_front();
          if (e !== 8'(i)) begin errors++; $display("FAIL %s_spacing: cpuEn at index %0d expected %0d", name, i, e); end
        end
      end
      next_cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing: %0d pulses not seen", name, exp_q.size()); end
  endtask

  task automatic test_fast_run();
    int cnt;
    bus.bpEn    = 1'b0;
    bus.rateSel = 2'b10;
    load_model(3'd0, 12'h000);
    pulse_run();
    checks++; if (bus.stateOut !== 2'b01) begin errors++; $display("FAIL fast_state: got %b expected 01", bus.stateOut); end
    exp_q = '{8'd4, 8'd8, 8'd12};
    run_pulse_window("fast", 16);
    bus.rateSel = 2'b11;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cpuEn === 1'b1) cnt++;
      next_cycle();
    end
    checks++; if (cnt !== 8) begin errors++; $display("FAIL fast_continuous: got %0d expected 8", cnt); end
    pulse_run();
    checks++; if (bus.cpuEn !== 1'b0) begin errors++; $display("FAIL fast_stop_cpuEn: got %b expected 0", bus.cpuEn); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL fast_stop_halted: got %b expected 1", bus.halted); end
  endtask

  task automatic test_slow_run();
    bus.rateSel = 2'b01;
    next_cycle();
    pulse_run();
    exp_q = '{8'd6, 8'd12};
    run_pulse_window("slow", 14);
    pulse_run();
    checks++; if (bus.stateOut !== 2'b00) begin errors++; $display("FAIL slow_stop: got %b expected 00", bus.stateOut); end
  endtask

  task automatic test_breakpoint();
    int n;
    logic enAtBp;
    enAtBp      = 1'b0;
    bus.bpEn    = 1'b1;
    bus.bpAddr  = 12'h005;
    bus.rateSel = 2'b11;
    load_model(3'd0, 12'h002);
    pulse_run();
    n = 0;
    while (bus.halted !== 1'b1 && n < 100) begin
      if (bus.cpuEn === 1'b1 && mPc == 12'h005 && mCyc == 3'd0) enAtBp = 1'b1;
      next_cycle();
      n++;
    end
    checks++; if (n !== 25) begin errors++; $display("FAIL bp_latency: halted after %0d cycles expected 25", n); end
    checks++; if (bus.bpHit !== 1'b1) begin errors++; $display("FAIL bp_hit: got %b expected 1", bus.bpHit); end
    checks++; if (mPc !== 12'h005) begin errors++; $display("FAIL bp_pc: got %h expected 005", mPc); end
    checks++; if (mCyc !== 3'd0) begin errors++; $display("FAIL bp_cycle: got %0d expected 0", mCyc); end
    checks++; if (enAtBp !== 1'b0) begin errors++; $display("FAIL bp_no_exec: got %b expected 0", enAtBp); end
  endtask

  task automatic test_bp_resume();
    int n;
    pulse_run();
    checks++; if (bus.bpHit !== 1'b0) begin errors++; $display("FAIL resume_bpHit: got %b expected 0", bus.bpHit); end
    checks++; if (bus.cpuEn !== 1'b1) begin errors++; $display("FAIL resume_cpuEn: got %b expected 1", bus.cpuEn); end
    for (int i = 0; i < 16; i++) next_cycle();
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_no_rehalt: got %b expected 0", bus.halted); end
    checks++; if (mPc !== 12'h007) begin errors++; $display("FAIL resume_pc: got %h expected 007", mPc); end
    load_model(3'd0, 12'h003);
    n = 0;
    while (bus.halted !== 1'b1 && n < 100) begin
      next_cycle();
      n++;
    end
    checks++; if (n !== 17) begin errors++; $display("FAIL rehit_latency: halted after %0d cycles expected 17", n); end
    checks++; if (mPc !== 12'h005) begin errors++; $display("FAIL rehit_pc: got %h expected 005", mPc); end
    checks++; if (bus.bpHit !== 1'b1) begin errors++; $display("FAIL rehit_bpHit: got %b expected 1", bus.bpHit); end
    bus.bpEn = 1'b0;
  endtask

  task automatic test_priorities();
    logic [2:0] cycSnap;
    bus.rateSel  = 2'b00;
    bus.stepMode = 1'b0;
    bus.runReq   = 1'b1;
    bus.stepReq  = 1'b1;
    next_cycle();
    bus.runReq   = 1'b0;
    bus.stepReq  = 1'b0;
    checks++; if (bus.stateOut !== 2'b01) begin errors++; $display("FAIL prio_run_wins: got %b expected 01", bus.stateOut); end
    checks++; if (bus.cpuEn !== 1'b0) begin errors++; $display("FAIL prio_paused_cpuEn: got %b expected 0", bus.cpuEn); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL prio_paused_halted: got %b expected 0", bus.halted); end
    cycSnap = mCyc;
    pulse_step(1'b0);
    checks++; if (bus.stateOut !== 2'b01) begin errors++; $display("FAIL prio_step_in_run: got %b expected 01", bus.stateOut); end
    next_cycle();
    next_cycle();
    checks++; if (mCyc !== cycSnap) begin errors++; $display("FAIL prio_no_advance: cycle got %0d expected %0d", mCyc, cycSnap); end
    pulse_run();
    checks++; if (bus.stateOut !== 2'b00) begin errors++; $display("FAIL prio_halt: got %b expected 00", bus.stateOut); end
  endtask

  task automatic test_reset_abort();
    load_model(3'd1, 12'h200);
    pulse_step(1'b1);
    checks++; if (bus.stateOut !== 2'b11) begin errors++; $display("FAIL abort_stepins: got %b expected 11", bus.stateOut); end
    next_cycle();
    #3;
    rstN = 1'b0;
    #1;
    checks++; if (bus.cpuEn !== 1'b0) begin errors++; $display("FAIL abort_cpuEn: got %b expected 0", bus.cpuEn); end
    checks++; if (bus.stateOut !== 2'b00) begin errors++; $display("FAIL abort_state: got %b expected 00", bus.stateOut); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL abort_halted: got %b expected 1", bus.halted); end
    next_cycle();
    next_cycle();
    rstN = 1'b1;
    next_cycle();
    next_cycle();
    checks++; if (mCyc !== 3'd2) begin errors++; $display("FAIL abort_cycle: got %0d expected 2", mCyc); end
    checks++; if (bus.stateOut !== 2'b00) begin errors++; $display("FAIL abort_after: got %b expected 00", bus.stateOut); end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rstN         = 1'b0;
    bus.rateSel  = 2'b00;
    bus.runReq   = 1'b0;
    bus.stepReq  = 1'b0;
    bus.stepMode = 1'b0;
    bus.bpAddr   = 12'h000;
    bus.bpEn     = 1'b0;
    mLoad        = 1'b0;
    mLoadCyc     = 3'd0;
    mLoadPc      = 12'h000;

    test_reset();
    test_step_cyc();
    test_step_ins();
    test_fast_run();
    test_slow_run();
    test_breakpoint();
    test_bp_resume();
    test_priorities();
    test_reset_abort();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
